// File: rtl/comp_4_sync.sv
// comp_4_sync: registered magnitude comparator with registered max/min.
//
// Compares a and b on every cycle where in_valid is high. One clock edge
// later it presents a one-hot relation, the larger and the smaller operand,
// and a single-cycle out_valid pulse. With SIGNED_CMP = 0 the operands are
// unsigned. With SIGNED_CMP = 1 they are two's complement.
//
// Ports:
//   clk        input           rising-edge system clock
//   rst_n      input           asynchronous active-low reset
//   in_valid   input           a/b valid this cycle; capture and compare
//   a          input  [W-1:0]  operand A
//   b          input  [W-1:0]  operand B
//   y          output [2:0]    one-hot: [2] a>b, [1] a==b, [0] a<b
//   out_valid  output          y/max_out/min_out updated at this edge
//   max_out    output [W-1:0]  larger operand (a when equal)
//   min_out    output [W-1:0]  smaller operand (b when equal)
module comp_4_sync #(
    parameter int WIDTH      = 4,
    parameter int SIGNED_CMP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       y,
    output logic             out_valid,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out
);

    // Inverting the sign bit maps two's-complement order onto unsigned
    // order. One unsigned comparator then serves both builds.
    function automatic logic [WIDTH-1:0] to_key(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] k;
        k = x;
        if (SIGNED_CMP != 0) begin
            k[WIDTH-1] = ~x[WIDTH-1];
        end
        return k;
    endfunction

    logic [WIDTH-1:0] w_key_a;
    logic [WIDTH-1:0] w_key_b;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;

    // Equality is bitwise identity. The sign-bit flip does not change it.
    assign w_key_a = to_key(a);
    assign w_key_b = to_key(b);
    assign w_eq    = (a == b);
    assign w_gt    = (w_key_a > w_key_b);
    assign w_lt    = ~w_gt & ~w_eq;

    logic [2:0]       r_y_p0;
    logic             r_vld_p0;
    logic [WIDTH-1:0] r_max_p0;
    logic [WIDTH-1:0] r_min_p0;

    // Stage p0: capture the relation and max/min. These hold while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_p0   <= 3'b000;
            r_vld_p0 <= 1'b0;
            r_max_p0 <= '0;
            r_min_p0 <= '0;
        end else begin
            r_vld_p0 <= in_valid;
            if (in_valid) begin
                r_y_p0   <= {w_gt, w_eq, w_lt};
                r_max_p0 <= w_lt ? b : a;
                r_min_p0 <= w_lt ? a : b;
            end
        end
    end

    assign y         = r_y_p0;
    assign out_valid = r_vld_p0;
    assign max_out   = r_max_p0;
    assign min_out   = r_min_p0;

endmodule

// File: tb/tb_comp_4_sync.sv
module tb_comp_4_sync;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [2:0]   y_u, y_s;
    logic         vld_u, vld_s;
    logic [W-1:0] max_u, min_u, max_s, min_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    comp_4_sync #(.WIDTH(W), .SIGNED_CMP(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .y(y_u), .out_valid(vld_u), .max_out(max_u), .min_out(min_u)
    );

    comp_4_sync #(.WIDTH(W), .SIGNED_CMP(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .y(y_s), .out_valid(vld_s), .max_out(max_s), .min_out(min_s)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Numeric value of an operand under either interpretation.
    function automatic int val(input bit sgn, input logic [W-1:0] x);
        int v;
        v = int'(x);
        if (sgn && x[W-1]) v = v - (1 << W);
        return v;
    endfunction

    // Reference model: m_*[0] is the unsigned build, m_*[1] the signed one.
    logic [2:0]   m_y   [2];
    logic         m_vld [2];
    logic [W-1:0] m_max [2];
    logic [W-1:0] m_min [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_y[k]   <= 3'b000;
                m_vld[k] <= 1'b0;
                m_max[k] <= '0;
                m_min[k] <= '0;
            end else begin
                m_vld[k] <= in_valid;
                if (in_valid) begin
                    if (val(k[0], a) > val(k[0], b))       m_y[k] <= 3'b100;
                    else if (val(k[0], a) == val(k[0], b)) m_y[k] <= 3'b010;
                    else                                   m_y[k] <= 3'b001;
                    m_max[k] <= (val(k[0], a) >= val(k[0], b)) ? a : b;
                    m_min[k] <= (val(k[0], a) >= val(k[0], b)) ? b : a;
                end
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("u_y",   {29'd0, y_u},   {29'd0, m_y[0]});
            check("u_vld", {31'd0, vld_u}, {31'd0, m_vld[0]});
            check("u_max", {28'd0, max_u}, {28'd0, m_max[0]});
            check("u_min", {28'd0, min_u}, {28'd0, m_min[0]});
            check("s_y",   {29'd0, y_s},   {29'd0, m_y[1]});
            check("s_vld", {31'd0, vld_s}, {31'd0, m_vld[1]});
            check("s_max", {28'd0, max_s}, {28'd0, m_max[1]});
            check("s_min", {28'd0, min_s}, {28'd0, m_min[1]});
            if (vld_u) check("u_onehot", $countones(y_u), 1);
            if (vld_s) check("s_onehot", $countones(y_s), 1);
        end
    end

    // Apply inputs, let one edge capture them, and return 1 time unit later.
    task automatic step(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb);
        in_valid = v;
        a = va;
        b = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        check("rst0_y",   {29'd0, y_u}, 0);
        check("rst0_vld", {31'd0, vld_u}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Equal (unsigned)
        step(1, 4'b1111, 4'b1111);
        check("eq_y",   {29'd0, y_u}, 3'b010);
        check("eq_max", {28'd0, max_u}, 15);
        check("eq_min", {28'd0, min_u}, 15);
        check("eq_vld", {31'd0, vld_u}, 1);
        check("eq_model", {29'd0, m_y[0]}, 3'b010);

        // Greater (unsigned), and the same operands in the signed build
        step(1, 4'b1001, 4'b0110);
        check("gt_y",   {29'd0, y_u}, 3'b100);
        check("gt_max", {28'd0, max_u}, 9);
        check("gt_min", {28'd0, min_u}, 6);
        check("sg_y",   {29'd0, y_s}, 3'b001);
        check("sg_max", {28'd0, max_s}, 4'b0110);
        check("sg_min", {28'd0, min_s}, 4'b1001);
        check("sg_model", {29'd0, m_y[1]}, 3'b001);

        // Less (unsigned)
        step(1, 4'b0011, 4'b0100);
        check("lt_y",   {29'd0, y_u}, 3'b001);
        check("lt_max", {28'd0, max_u}, 4);
        check("lt_min", {28'd0, min_u}, 3);

        // Back-to-back valid inputs, then idle: y holds the last result
        step(1, 4'd5, 4'd2);
        check("b2b1_vld", {31'd0, vld_u}, 1);
        step(1, 4'd7, 4'd7);
        check("b2b2_vld", {31'd0, vld_u}, 1);
        step(1, 4'd1, 4'd8);
        check("b2b3_vld", {31'd0, vld_u}, 1);
        step(0, 4'd9, 4'd0);
        check("idle_vld", {31'd0, vld_u}, 0);
        check("idle_y",   {29'd0, y_u}, 3'b001);
        check("idle_max", {28'd0, max_u}, 8);
        step(0, 4'd0, 4'd9);
        check("idle2_y",  {29'd0, y_u}, 3'b001);

        // Asynchronous reset in mid-cycle with y = 100 beforehand
        step(1, 4'b1001, 4'b0110);
        check("pre_rst_y", {29'd0, y_u}, 3'b100);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 4'd12;
        b = 4'd3;
        #1;
        check("arst_y",   {29'd0, y_u}, 0);
        check("arst_vld", {31'd0, vld_u}, 0);
        check("arst_max", {28'd0, max_u}, 0);
        check("arst_min", {28'd0, min_u}, 0);
        @(posedge clk);
        #1;
        check("rst_discard_y",   {29'd0, y_u}, 0);
        check("rst_discard_vld", {31'd0, vld_u}, 0);
        rst_n = 1'b1;
        step(0, 4'd0, 4'd0);
        check("post_rst_y", {29'd0, y_u}, 0);

        // Randomized traffic with edge values mixed in
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (($urandom & 7) == 0) ? ra : W'($urandom);
            if (($urandom & 15) == 0) ra = 4'b1000;
            if (($urandom & 15) == 0) rb = 4'b0111;
            step(($urandom & 3) != 0, ra, rb);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/comp_4_sync.md
Name: comp_4_sync

Overview:
- Registered 4-bit magnitude comparator.
- Compares operands a and b and drives a one-hot result y: greater, equal or less.
- Sits in the datapath wherever a registered relational decision on two small unsigned or signed operands is needed.
- Also provides registered max/min of the operands.

Parameters:
WIDTH, 4, operand width in bits (min 1).
SIGNED_CMP, 0, 0 = unsigned compare; 1 = two's-complement signed compare.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  a/b are valid this cycle; capture and compare.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
y  output  3  one-hot result; y[2] = a>b, y[1] = a==b, y[0] = a<b.
out_valid  output  1  y/max_out/min_out updated on this cycle's edge.
max_out  output  WIDTH  larger of a, b (a when equal).
min_out  output  WIDTH  smaller of a, b (b when equal).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asserts immediately without waiting for a clock edge):
  - y = 3'b000, out_valid = 0, max_out = 0, min_out = 0.
  - Release is sampled at the next rising clk edge.
- Latency is 1 cycle: a/b sampled with in_valid = 1 at edge N produce y/max_out/min_out/out_valid at edge N (visible after edge N).
- out_valid is a single-cycle pulse per accepted input. Back-to-back in_valid gives back-to-back results; no stalls and no backpressure.
- in_valid = 0 at an edge: out_valid drops to 0; y, max_out and min_out hold their previous values.
- Comparison:
  - SIGNED_CMP = 0: operands are treated as unsigned 0..2^WIDTH-1.
  - SIGNED_CMP = 1: operands are treated as two's complement; the MSB is the sign.
  - Exactly one y bit is set whenever out_valid = 1.
  - y = 3'b100 if a>b, 3'b010 if a==b, 3'b001 if a<b.
  - y = 3'b000 only between reset and the first accepted input.
- Equality is bitwise identity, regardless of SIGNED_CMP.
- The combinational compare path has no X-propagation requirement beyond standard RTL semantics.
- Reset mid-operation: outputs clear immediately. An input accepted in the same cycle as reset assertion is discarded.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with prior y = 3'b100 -> y = 000, out_valid = 0 and max/min = 0 immediately, without a clock edge.
- Equal (unsigned): a = 4'b1111, b = 4'b1111, in_valid = 1 -> next edge y = 3'b010, max_out = 15, min_out = 15, out_valid = 1.
- Greater (unsigned): a = 4'b1001, b = 4'b0110 -> y = 3'b100, max_out = 9, min_out = 6.
- Less (unsigned): a = 4'b0011, b = 4'b0100 -> y = 3'b001, max_out = 4, min_out = 3.
- Signed build (SIGNED_CMP = 1): a = 4'b1001 (-7), b = 4'b0110 (+6) -> y = 3'b001, max_out = 4'b0110, min_out = 4'b1001.
- Hold/valid: three back-to-back valid inputs, then in_valid = 0 -> out_valid high for exactly 3 cycles, then 0; y holds the last result (3'b001 for the less case).
